// File: rtl/iz_pkg.sv
// iz_pkg: shared constants and types for the Izhikevich neuron and its
// byte-serial parameter loader. All parameter values are signed 16-bit,
// scaled by SCALE (64).
// Optional build macro used by the loader: IZ_LOADER_CHECKSUM_EN.
package iz_pkg;

  // Fixed-point scale shared with iz_neuron_with_loader
  localparam int unsigned SCALE = 64;

  // Voltage constants, scaled by SCALE
  localparam logic signed [15:0] V_RESET = -16'sd4160;  // -65 mV
  localparam logic signed [15:0] V_PEAK  = 16'sd1920;   // +30 mV

  // Regular-spiking defaults, scaled by SCALE
  localparam logic signed [15:0] DEFAULT_A = 16'sd1;      // 0.02
  localparam logic signed [15:0] DEFAULT_B = 16'sd13;     // 0.2
  localparam logic signed [15:0] DEFAULT_C = -16'sd4160;  // -65 mV
  localparam logic signed [15:0] DEFAULT_D = 16'sd512;    // 8

  // Frame start marker
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Frame lengths after the sync byte
  localparam int unsigned DATA_BYTES          = 8;
  localparam int unsigned CHECKSUM_FRAME_BYTES = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } loader_state_e;

endpackage

// File: rtl/iz_loader_timeout.sv
// iz_loader_timeout: inter-strobe cycle counter for the parameter loader.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clear       - force the count back to zero (has priority over enable)
//   enable      - count one cycle
//   expired_c   - combinational: count has reached TIMEOUT_CYCLES-1
module iz_loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count;

  assign expired_c = (count == CW'(TIMEOUT_CYCLES - 1));

  // Counter holds at the expiry value until cleared
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired_c) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/iz_param_loader.sv
// iz_param_loader: assembles the four 16-bit Izhikevich parameters from a
// byte-serial load bus. Frame = SYNC_BYTE, a_hi, a_lo, b_hi, b_lo, c_hi,
// c_lo, d_hi, d_lo (plus an XOR check byte when IZ_LOADER_CHECKSUM_EN is
// defined). Parameters are double-buffered: only a complete frame is
// committed to the outputs.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   load_strobe         - byte valid, one byte per high cycle
//   load_data[7:0]      - byte qualified by load_strobe
//   param_a..param_d    - committed parameters (signed, scaled by 64)
//   params_ready        - committed set valid and no frame in progress
//   busy                - frame in progress
//   frame_error         - one-cycle pulse on abort (timeout/check mismatch)
// Build macro: IZ_LOADER_CHECKSUM_EN (adds the trailing XOR check byte).
module iz_param_loader
  import iz_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_strobe,
  input  logic [7:0]  load_data,
  output logic [15:0] param_a,
  output logic [15:0] param_b,
  output logic [15:0] param_c,
  output logic [15:0] param_d,
  output logic        params_ready,
  output logic        busy,
  output logic        frame_error
);

`ifdef IZ_LOADER_CHECKSUM_EN
  localparam int unsigned FRAME_BYTES = CHECKSUM_FRAME_BYTES;
`else
  localparam int unsigned FRAME_BYTES = DATA_BYTES;
`endif
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BYTES - 1);

  loader_state_e    state;
  loader_state_e    state_next;
  logic [CNT_W-1:0] byte_cnt;
  logic [7:0]       shadow [DATA_BYTES];
  logic             committed_valid;

  logic             abort_c;
  logic             take_byte_c;
  logic             tmo_expired_c;
  logic             tmo_clear_c;
  logic             in_load_c;

  assign in_load_c   = (state == ST_LOAD);
  assign tmo_clear_c = !in_load_c || load_strobe;

  iz_loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear    (tmo_clear_c),
    .enable   (in_load_c),
    .expired_c(tmo_expired_c)
  );

`ifdef IZ_LOADER_CHECKSUM_EN
  logic [7:0] frame_xor_c;

  // Running XOR of the data bytes already captured
  always_comb begin
    frame_xor_c = '0;
    for (int i = 0; i < int'(DATA_BYTES); i++) begin
      frame_xor_c = frame_xor_c ^ shadow[i];
    end
  end
`endif

  // Next-state and control decode
  always_comb begin
    state_next  = state;
    abort_c     = 1'b0;
    take_byte_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load_strobe && (load_data == SYNC_BYTE)) begin
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Timeout wins over a coincident strobe
        if (tmo_expired_c) begin
          abort_c    = 1'b1;
          state_next = ST_IDLE;
        end else if (load_strobe) begin
          take_byte_c = (byte_cnt < CNT_W'(DATA_BYTES));
          if (byte_cnt == LAST_IDX) begin
`ifdef IZ_LOADER_CHECKSUM_EN
            if (load_data == frame_xor_c) begin
              state_next = ST_COMMIT;
            end else begin
              abort_c    = 1'b1;
              state_next = ST_IDLE;
            end
`else
            state_next = ST_COMMIT;
`endif
          end
        end
      end
      ST_COMMIT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State, shadow buffer and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      byte_cnt        <= '0;
      committed_valid <= 1'b0;
      param_a         <= DEFAULT_A;
      param_b         <= DEFAULT_B;
      param_c         <= DEFAULT_C;
      param_d         <= DEFAULT_D;
      params_ready    <= 1'b0;
      busy            <= 1'b0;
      frame_error     <= 1'b0;
      for (int i = 0; i < int'(DATA_BYTES); i++) begin
        shadow[i] <= '0;
      end
    end else begin
      state       <= state_next;
      busy        <= (state_next == ST_LOAD);
      frame_error <= abort_c;

      if (!in_load_c) begin
        byte_cnt <= '0;
      end else if (load_strobe && !tmo_expired_c) begin
        byte_cnt <= byte_cnt + CNT_W'(1);
      end

      if (take_byte_c) begin
        shadow[byte_cnt[2:0]] <= load_data;
      end else if (abort_c) begin
        for (int i = 0; i < int'(DATA_BYTES); i++) begin
          shadow[i] <= '0;
        end
      end

      if (state == ST_COMMIT) begin
        param_a         <= {shadow[0], shadow[1]};
        param_b         <= {shadow[2], shadow[3]};
        param_c         <= {shadow[4], shadow[5]};
        param_d         <= {shadow[6], shadow[7]};
        committed_valid <= 1'b1;
      end

      // Ready tracks the committed set, held low while a frame is open
      params_ready <= (committed_valid || (state == ST_COMMIT)) &&
                      (state_next == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_iz_param_loader.sv
// Bench for iz_param_loader: transaction-level reference model checked every
// cycle, plus literal expectations at key points of the directed sequence.
module tb_iz_param_loader;

  localparam int T = 1024;
`ifdef IZ_LOADER_CHECKSUM_EN
  localparam int FLEN = 9;
`else
  localparam int FLEN = 8;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        load_strobe;
  logic [7:0]  load_data;
  logic [15:0] param_a, param_b, param_c, param_d;
  logic        params_ready, busy, frame_error;

  int checks = 0;
  int failures = 0;
  int err_seen = 0;

  iz_param_loader #(.TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_strobe (load_strobe),
    .load_data   (load_data),
    .param_a     (param_a),
    .param_b     (param_b),
    .param_c     (param_c),
    .param_d     (param_d),
    .params_ready(params_ready),
    .busy        (busy),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  // Reference model: frame-level view of the loader
  bit          m_started = 0;
  bit          m_in_frame, m_pend, m_valid, m_err;
  logic [7:0]  m_bytes[$];
  int          m_gap;
  logic [15:0] m_a, m_b, m_c, m_d;
  logic [7:0]  m_x;

  always @(posedge clk) begin
    if (reset) begin
      m_started = 1; m_in_frame = 0; m_pend = 0; m_valid = 0; m_err = 0;
      m_bytes.delete(); m_gap = 0;
      m_a = 16'h0001; m_b = 16'h000D; m_c = 16'hEFC0; m_d = 16'h0200;
    end else if (m_started) begin
      m_err = 0;
      if (m_pend) begin
        m_a = {m_bytes[0], m_bytes[1]};
        m_b = {m_bytes[2], m_bytes[3]};
        m_c = {m_bytes[4], m_bytes[5]};
        m_d = {m_bytes[6], m_bytes[7]};
        m_valid = 1; m_pend = 0;
      end else if (m_in_frame) begin
        if (m_gap == T - 1) begin
          m_err = 1; m_in_frame = 0;
        end else if (load_strobe) begin
          m_bytes.push_back(load_data);
          m_gap = 0;
          if (m_bytes.size() == FLEN) begin
            m_in_frame = 0;
`ifdef IZ_LOADER_CHECKSUM_EN
            m_x = 8'h00;
            for (int i = 0; i < 8; i++) m_x = m_x ^ m_bytes[i];
            if (m_x == m_bytes[8]) m_pend = 1;
            else m_err = 1;
`else
            m_pend = 1;
`endif
          end
        end else begin
          m_gap++;
        end
      end else if (load_strobe && load_data == 8'hA5) begin
        m_in_frame = 1; m_bytes.delete(); m_gap = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_started) begin
      chk("param_a", param_a, m_a);
      chk("param_b", param_b, m_b);
      chk("param_c", param_c, m_c);
      chk("param_d", param_d, m_d);
      chk("params_ready", 16'(params_ready), 16'(m_valid && !m_in_frame && !m_pend));
      chk("busy", 16'(busy), 16'(m_in_frame));
      chk("frame_error", 16'(frame_error), 16'(m_err));
    end
    if (frame_error === 1'b1) err_seen++;
  end

  // Called at a negedge; strobes one byte across the next rising edge
  task automatic send(input logic [7:0] b);
    load_strobe = 1'b1;
    load_data   = b;
    @(negedge clk);
    load_strobe = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d,
                            input bit bad_check);
    logic [7:0] f [8];
    logic [7:0] x;
    f[0] = a[15:8]; f[1] = a[7:0]; f[2] = b[15:8]; f[3] = b[7:0];
    f[4] = c[15:8]; f[5] = c[7:0]; f[6] = d[15:8]; f[7] = d[7:0];
    x = 8'h00;
    send(8'hA5);
    for (int i = 0; i < 8; i++) begin
      x = x ^ f[i];
      send(f[i]);
    end
`ifdef IZ_LOADER_CHECKSUM_EN
    send(bad_check ? 8'hFF : x);
`else
    if (bad_check) x = 8'h00;
`endif
  endtask

  int e0;

  initial begin
    reset = 1'b1; load_strobe = 1'b0; load_data = 8'h00;
    idle(3);
    reset = 1'b0;

    // Reset defaults
    chk("rst_a", param_a, 16'h0001);
    chk("rst_b", param_b, 16'h000D);
    chk("rst_c", param_c, 16'hEFC0);
    chk("rst_d", param_d, 16'h0200);
    chk("rst_ready", 16'(params_ready), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);

    // First frame and commit latency
    send_frame(16'h0002, 16'h000D, 16'hEFC0, 16'h0100, 1'b0);
    chk("lat_n1_ready", 16'(params_ready), 16'h0);
    chk("lat_n1_a", param_a, 16'h0001);
    idle(1);
    chk("lat_n2_ready", 16'(params_ready), 16'h1);
    chk("commit_a", param_a, 16'h0002);
    chk("commit_d", param_d, 16'h0100);

    // Timeout abort after a partial frame
    e0 = err_seen;
    send(8'hA5);
    chk("load_busy", 16'(busy), 16'h1);
    chk("load_ready", 16'(params_ready), 16'h0);
    send(8'h11); send(8'h22); send(8'h33);
    idle(T + 5);
    chk("tmo_pulses", 16'(err_seen - e0), 16'h1);
    chk("tmo_a_kept", param_a, 16'h0002);
    chk("tmo_ready", 16'(params_ready), 16'h1);

    // Strobe coincident with timeout expiry is dropped
    send(8'hA5);
    send(8'h44);
    idle(T - 1);
    send(8'h55);
    chk("tmo_wins_err", 16'(frame_error), 16'h1);
    chk("tmo_wins_busy", 16'(busy), 16'h0);
    idle(2);

    // Noise bytes in idle, then sync, then reset mid-frame
    e0 = err_seen;
    send(8'h12); send(8'h34);
    chk("noise_busy", 16'(busy), 16'h0);
    send(8'hA5);
    chk("sync_busy", 16'(busy), 16'h1);
    chk("noise_no_err", 16'(err_seen - e0), 16'h0);
    for (int i = 0; i < 5; i++) send(8'h60 + 8'(i));
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("mid_rst_a", param_a, 16'h0001);
    chk("mid_rst_c", param_c, 16'hEFC0);
    chk("mid_rst_ready", 16'(params_ready), 16'h0);
    chk("mid_rst_busy", 16'(busy), 16'h0);

    // Frame carrying sync bytes as data
    send_frame(16'hA5A5, 16'h0014, 16'hF000, 16'h0180, 1'b0);
    idle(1);
    chk("sync_data_a", param_a, 16'hA5A5);
    chk("post_rst_c", param_c, 16'hF000);
    chk("post_rst_ready", 16'(params_ready), 16'h1);

    // Strobe during the commit cycle is ignored
    send_frame(16'h0007, 16'h0008, 16'h0009, 16'h000A, 1'b0);
    send(8'hA5);
    chk("commit_strobe_busy", 16'(busy), 16'h0);
    chk("commit_strobe_a", param_a, 16'h0007);
    idle(2);

`ifdef IZ_LOADER_CHECKSUM_EN
    // Corrupted check byte aborts without touching the outputs
    e0 = err_seen;
    send_frame(16'h0002, 16'h000D, 16'hEFC0, 16'h0100, 1'b1);
    chk("cks_err", 16'(frame_error), 16'h1);
    idle(2);
    chk("cks_pulses", 16'(err_seen - e0), 16'h1);
    chk("cks_a_kept", param_a, 16'h0007);
    chk("cks_ready", 16'(params_ready), 16'h1);
`endif

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iz_param_loader.md
Name: iz_param_loader

Overview:
- Upstream stage of iz_neuron_with_loader: assembles the four 16-bit Izhikevich parameters (a, b, c, d) from a byte-serial 8-pin load bus.
- Presents the parameters with a params_ready qualifier.
- Parameters are double-buffered: the neuron only ever sees a complete, committed set. A partial or aborted frame never reaches the outputs.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1024, maximum clk cycles between strobes inside a frame before abort (>=2).
- DEFAULT_A, 16'sd1, reset value of param_a (0.02 scaled by 64).
- DEFAULT_B, 16'sd13, reset value of param_b (0.2 scaled by 64).
- DEFAULT_C, -16'sd4160, reset value of param_c (-65 mV scaled by 64).
- DEFAULT_D, 16'sd512, reset value of param_d (8 scaled by 64).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- load_strobe  in  1  byte valid, sampled each cycle; one byte per high cycle.
- load_data  in  8  byte qualified by load_strobe.
- param_a  out  16  committed parameter a (signed, scaled by 64).
- param_b  out  16  committed parameter b.
- param_c  out  16  committed parameter c.
- param_d  out  16  committed parameter d.
- params_ready  out  1  committed set valid and no frame in progress.
- busy  out  1  frame in progress (state LOAD).
- frame_error  out  1  one-cycle pulse on abort.

Behaviour:
- Reset: param_a..d = DEFAULT_A..D; params_ready=0; busy=0; frame_error=0; state=IDLE; byte counter=0; committed_valid=0; shadow registers=0. Reset mid-frame discards the frame.
- Frame format: SYNC_BYTE, then 8 data bytes in order a_hi, a_lo, b_hi, b_lo, c_hi, c_lo, d_hi, d_lo (MSB byte first).
- IDLE:
  - Strobe with load_data==SYNC_BYTE -> LOAD, counter=0, timeout cleared.
  - Any other strobed byte is ignored, with no error.
- LOAD:
  - Each strobe writes load_data into shadow byte[counter] and increments counter.
  - The strobe that writes byte 7 -> COMMIT.
  - SYNC_BYTE inside LOAD is treated as data, not a restart.
- COMMIT (single cycle):
  - Shadows copied to param_a..d; committed_valid=1.
  - Return to IDLE; params_ready=1 on the following cycle.
  - Latency: last data strobe at cycle N -> new params visible and params_ready=1 at cycle N+2.
  - A strobe during COMMIT is ignored.
- params_ready = committed_valid AND (state==IDLE), registered.
  - Goes to 0 the cycle after the sync byte is accepted; this freezes the neuron during reload.
- Timeout:
  - In LOAD, the counter increments every cycle without a strobe and clears on each strobe.
  - Reaching TIMEOUT_CYCLES-1 -> abort.
- Abort:
  - frame_error=1 for one cycle; state=IDLE.
  - Shadows are discarded; param_a..d unchanged.
  - params_ready returns to committed_valid (1 if any earlier commit succeeded, else 0).
- Strobe on the same cycle the timeout fires: the timeout wins; the byte is dropped.
- busy=1 exactly while state==LOAD.

Optional Feature:
- Macro: IZ_LOADER_CHECKSUM_EN.
- Enabled:
  - The frame carries a 9th byte, equal to the XOR of the 8 data bytes.
  - COMMIT occurs only if it matches.
  - Mismatch -> abort path (frame_error pulse, outputs unchanged).
  - Latency is measured from the checksum strobe.
- Disabled:
  - Frame is 8 data bytes.
  - No checksum logic is synthesised.

Decomposition:
- Package iz_pkg:
  - loader state enum (IDLE, LOAD, COMMIT);
  - SCALE=64;
  - SYNC_BYTE;
  - default regular-spiking constants DEFAULT_A..D;
  - frame length constants (8, 9).
  - iz_neuron_with_loader shares the SCALE and voltage constants.
- One sub-module: iz_loader_timeout, a cycle counter with clear/enable and an expired output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Reset -> param_a=1, b=13, c=0xEFC0, d=0x0200; params_ready=0; busy=0.
- Strobe A5,00,02,00,0D,EF,C0,01,00 on consecutive cycles -> a=2, b=13, c=0xEFC0, d=0x0100; params_ready=1 two cycles after the last byte.
- With params committed:
  - send A5 then 3 bytes, then idle 1024 cycles -> frame_error pulse;
  - params unchanged;
  - params_ready low during LOAD, high again after abort.
- Bytes 12,34,A5 while IDLE -> only A5 starts a frame; busy=1 the next cycle; no error.
- Assert reset after the 5th data byte -> all outputs return to defaults; params_ready=0; a following full frame commits correctly.
- IZ_LOADER_CHECKSUM_EN:
  - frame with correct XOR byte -> commit;
  - same frame with the XOR byte flipped to 0xFF -> frame_error, params unchanged.
